// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider; the div_mode encodings are also used by Decode.
`ifndef WORD
`define WORD 64
`endif

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic DIV_UNSIGNED = 1'b0;
  localparam logic DIV_SIGNED   = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, compare against the divisor, subtract.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic             ge;

  // The stored partial remainder is always below the divisor, so only the shifted
  // value needs the extra bit; the difference always fits back into WIDTH bits.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign quo_sh = {quo_i[WIDTH-2:0], 1'b0};
  assign ge     = (rem_sh >= {1'b0, divisor_i});

  always_comb begin
    rem_o = rem_sh[WIDTH-1:0];
    quo_o = quo_sh;
    if (ge) begin
      rem_o = rem_sh[WIDTH-1:0] - divisor_i;
      quo_o = {quo_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for UDIV/SDIV: one quotient bit per cycle,
// sign fix-up on the last step, ARMv8 divide-by-zero semantics (no trap).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divider_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
  logic             busy_q;

  logic             is_signed;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dsr_mag_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Magnitudes as unsigned WIDTH-bit values; MIN stays 2^(WIDTH-1).
  always_comb begin
    is_signed = (div_mode == DIV_SIGNED);
    dvd_mag_d = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_mag_d = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_start) begin
            quo_q   <= dvd_mag_d;
            dsr_q   <= dsr_mag_d;
            qneg_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q  <= is_signed && dividend[WIDTH-1];
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (dsr_q == '0) begin
            // Divide by zero: undo the magnitude to return the raw dividend bits.
            quotient_q  <= '0;
            remainder_q <= rneg_q ? -quo_q : quo_q;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              quotient_q  <= qneg_q ? -step_quo : step_quo;
              remainder_q <= rneg_q ? -step_rem : step_rem;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign divider_done = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: latency, sign rules, divide-by-zero, restart, reset abort.
module tb_seq_divider;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_start;
  logic         div_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divider_done;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
    .div_mode     (div_mode),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .divider_done (divider_done),
    .busy         (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 (just after the accepting edge); returns the cycle in which done is seen, or -1.
  task automatic wait_done(input int budget, output int cyc, output int busy_n);
    cyc    = 1;
    busy_n = 0;
    forever begin
      if (busy) busy_n++;
      if (divider_done) break;
      if (cyc >= budget) begin
        cyc = -1;
        break;
      end
      tick;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int elat, input int poke_at);
    int cyc;
    int bn;
    div_mode  = mode;
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    tick;
    div_start = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    fork
      wait_done(200, cyc, bn);
      begin
        if (poke_at > 0) begin
          repeat (poke_at - 1) tick;
          div_start = 1'b1;
          div_mode  = 1'b0;
          dividend  = 64'd5;
          divisor   = 64'd2;
          tick;
          div_start = 1'b0;
        end
      end
    join
    check_val({tag, " latency"}, 64'(cyc), 64'(elat));
    check_val({tag, " quotient"}, quotient, eq);
    check_val({tag, " remainder"}, remainder, er);
    check_val({tag, " busy_cycles"}, 64'(bn), 64'(elat));
    $display("op %s: q=%h r=%h done_cycle=%0d", tag, quotient, remainder, cyc);
    tick;
    check_val({tag, " done_pulse"}, 64'(divider_done), 64'd0);
    check_val({tag, " busy_after"}, 64'(busy), 64'd0);
    check_val({tag, " q_held"}, quotient, eq);
  endtask

  initial begin
    int c1;
    int c2;
    int bn;
    int done_seen;

    reset     = 1'b1;
    div_start = 1'b0;
    div_mode  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick;
    tick;
    reset = 1'b0;
    check_val("rst quotient", quotient, 64'd0);
    check_val("rst remainder", remainder, 64'd0);
    check_val("rst done", 64'(divider_done), 64'd0);
    check_val("rst busy", 64'(busy), 64'd0);
    $display("op reset: q=%h r=%h busy=%0d", quotient, remainder, busy);

    run_op("udiv_100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 0);
    run_op("sdiv_m100_7", 1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("sdiv_100_m7", 1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65, 0);
    run_op("udiv_by_zero", 1'b0, 64'h1234, 64'd0, 64'd0, 64'h1234, 2, 0);
    run_op("sdiv_neg_by_zero", 1'b1, -64'sd9, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7, 2, 0);
    run_op("sdiv_min_m1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 65, 0);
    run_op("udiv_big_sub", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
           64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("udiv_restart_ignored", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 20);

    // Reset in the middle of a division aborts it.
    div_mode  = 1'b0;
    dividend  = 64'd1000;
    divisor   = 64'd3;
    div_start = 1'b1;
    tick;
    div_start = 1'b0;
    repeat (29) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_val("abort busy", 64'(busy), 64'd0);
    check_val("abort quotient", quotient, 64'd0);
    check_val("abort remainder", remainder, 64'd0);
    check_val("abort done", 64'(divider_done), 64'd0);
    done_seen = 0;
    repeat (100) begin
      tick;
      if (divider_done) done_seen++;
    end
    check_val("abort no_done", 64'(done_seen), 64'd0);
    $display("op reset_abort: busy=%0d done_seen=%0d", busy, done_seen);
    run_op("udiv_9_3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65, 0);

    // Start held high across two operations.
    div_mode  = 1'b0;
    dividend  = 64'd50;
    divisor   = 64'd5;
    div_start = 1'b1;
    tick;
    dividend = 64'd81;
    divisor  = 64'd9;
    wait_done(200, c1, bn);
    check_val("held first latency", 64'(c1), 64'd65);
    check_val("held first quotient", quotient, 64'd10);
    check_val("held first remainder", remainder, 64'd0);
    $display("op held_first: q=%h r=%h done_cycle=%0d", quotient, remainder, c1);
    tick;
    wait_done(200, c2, bn);
    div_start = 1'b0;
    check_val("held gap", 64'(c2), 64'd66);
    check_val("held second quotient", quotient, 64'd9);
    check_val("held second remainder", remainder, 64'd0);
    $display("op held_second: q=%h r=%h gap=%0d", quotient, remainder, c2);
    tick;
    check_val("held done_pulse", 64'(divider_done), 64'd0);
    repeat (3) tick;
    check_val("held idle busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
